// File: rtl/code_lock_pkg.sv
// Shared types, constants and helpers for the code lock controller.
package code_lock_pkg;

  // Lock controller states.
  typedef enum logic [1:0] {
    LOCKED    = 2'd0,
    OPEN      = 2'd1,
    SET_ENTRY = 2'd2,
    LOCKOUT   = 2'd3
  } lock_state_e;

  // 7-segment patterns for digits 0..9, bit order {dp,g,f,e,d,c,b,a}, active-high.
  // Entry 9 is leftmost in the concatenation, entry 0 rightmost.
  localparam logic [9:0][8:0] SEG_TABLE = {
    9'h06f, 9'h07f, 9'h007, 9'h07d, 9'h06d,
    9'h066, 9'h04f, 9'h05b, 9'h006, 9'h03f
  };

  // Counter/index width that is never zero, even for tiny ranges.
  function automatic int clog2_min1(input int v);
    int w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

  // Decimal digit to segment pattern; out-of-range values blank the display.
  function automatic logic [8:0] seg_encode(input int d);
    if (d >= 0 && d <= 9) return SEG_TABLE[d];
    return 9'h000;
  endfunction

endpackage

// File: rtl/key_pulse_deb.sv
// Raw active-low push-button to single-cycle press pulse: synchroniser,
// slow periodic sampler (debounce) and falling-edge detector.
module key_pulse_deb
  import code_lock_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);

  localparam int CW = clog2_min1(DEB_CYCLES);

  logic          sync1_reg, sync2_reg;
  logic          sample_reg;
  logic          pulse_reg;
  logic [CW-1:0] cnt_reg;
  logic          tick;

  assign tick  = (cnt_reg == CW'(DEB_CYCLES - 1));
  assign pulse = pulse_reg;

  // Two-flop synchroniser; buttons idle high so reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
    end
  end

  // Free-running sample timebase; tick marks one sample point per period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
  end

  // Sample at each tick; a high->low change between samples is one press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_reg <= 1'b1;
      pulse_reg  <= 1'b0;
    end else begin
      pulse_reg <= tick && sample_reg && !sync2_reg;
      if (tick) sample_reg <= sync2_reg;
    end
  end

endmodule

// File: rtl/code_lock_ctrl.sv
// Multi-digit code lock: digit entry, retry budget, timed lockout,
// in-field code change and two-digit readout of remaining tries.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int PW_WIDTH       = 4,
  parameter int PW_DIGITS      = 4,
  parameter logic [PW_WIDTH*PW_DIGITS-1:0] PW_INIT = '0,
  parameter int MAX_TRIES      = 5,
  parameter int LOCKOUT_CYCLES = 50_000_000,
  parameter int DEB_CYCLES     = 1_000_000
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   key_chk_n,
  input  logic                                   key_rst_n,
  input  logic                                   key_set_n,
  input  logic [PW_WIDTH-1:0]                    pw_sw,
  output logic                                   is_open,
  output logic                                   locked_out,
  output logic                                   set_mode,
  output logic [clog2_min1(PW_DIGITS+1)-1:0]     digit_idx,
  output logic [clog2_min1(MAX_TRIES+1)-1:0]     tries_left,
  output logic [8:0]                             seg_tens,
  output logic [8:0]                             seg_ones
);

  localparam int CODE_W = PW_WIDTH * PW_DIGITS;
  localparam int IW     = clog2_min1(PW_DIGITS + 1);
  localparam int TW     = clog2_min1(MAX_TRIES + 1);
  localparam int LW     = clog2_min1(LOCKOUT_CYCLES);

  localparam logic [1:0] S_LOCKED    = LOCKED;
  localparam logic [1:0] S_OPEN      = OPEN;
  localparam logic [1:0] S_SET_ENTRY = SET_ENTRY;
  localparam logic [1:0] S_LOCKOUT   = LOCKOUT;

  logic [1:0]        state_reg;
  logic [CODE_W-1:0] code_reg;
  logic [CODE_W-1:0] buf_reg;
  logic [CODE_W-1:0] buf_ins;
  logic [IW-1:0]     digit_idx_reg;
  logic [TW-1:0]     tries_reg;
  logic [LW-1:0]     lock_cnt_reg;

  logic [2:0] keys_n;
  logic [2:0] key_pulse;
  logic       rst_p, set_p, chk_p;
  logic       last_digit, code_match;

  // Key order in the vectors: 0 = chk, 1 = rst, 2 = set.
  assign keys_n = {key_set_n, key_rst_n, key_chk_n};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      key_pulse_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (keys_n[gi]),
        .pulse (key_pulse[gi])
      );
    end
  endgenerate

  // rst beats set beats chk when pulses coincide; losers are dropped.
  assign rst_p = key_pulse[1];
  assign set_p = key_pulse[2] && !key_pulse[1];
  assign chk_p = key_pulse[0] && !key_pulse[1] && !key_pulse[2];

  // Entry buffer with the switches dropped into the current digit slot.
  generate
    for (genvar gi = 0; gi < PW_DIGITS; gi++) begin : g_buf
      assign buf_ins[gi*PW_WIDTH +: PW_WIDTH] =
        (digit_idx_reg == IW'(gi)) ? pw_sw : buf_reg[gi*PW_WIDTH +: PW_WIDTH];
    end
  endgenerate

  assign last_digit = (digit_idx_reg == IW'(PW_DIGITS - 1));
  assign code_match = (buf_ins == code_reg);

  // Lock state machine, entry buffer, retry budget and lockout timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_LOCKED;
      code_reg      <= PW_INIT;
      buf_reg       <= '0;
      digit_idx_reg <= '0;
      tries_reg     <= TW'(MAX_TRIES);
      lock_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        S_LOCKED: begin
          if (rst_p) begin
            digit_idx_reg <= '0;
            buf_reg       <= '0;
          end else if (chk_p) begin
            if (last_digit) begin
              digit_idx_reg <= '0;
              buf_reg       <= '0;
              if (code_match) begin
                state_reg <= S_OPEN;
                tries_reg <= TW'(MAX_TRIES);
              end else if (tries_reg != '0) begin
                tries_reg <= tries_reg - TW'(1);
                if (tries_reg == TW'(1)) begin
                  state_reg    <= S_LOCKOUT;
                  lock_cnt_reg <= LW'(LOCKOUT_CYCLES - 1);
                end
              end
            end else begin
              buf_reg       <= buf_ins;
              digit_idx_reg <= digit_idx_reg + IW'(1);
            end
          end
        end
        S_LOCKOUT: begin
          if (rst_p) buf_reg <= '0;
          if (lock_cnt_reg == '0) begin
            state_reg <= S_LOCKED;
            tries_reg <= TW'(MAX_TRIES);
          end else begin
            lock_cnt_reg <= lock_cnt_reg - LW'(1);
          end
        end
        S_OPEN: begin
          if (rst_p) begin
            state_reg     <= S_LOCKED;
            digit_idx_reg <= '0;
            buf_reg       <= '0;
          end else if (set_p) begin
            state_reg     <= S_SET_ENTRY;
            digit_idx_reg <= '0;
            buf_reg       <= '0;
          end
        end
        S_SET_ENTRY: begin
          if (rst_p) begin
            state_reg     <= S_OPEN;
            digit_idx_reg <= '0;
            buf_reg       <= '0;
          end else if (chk_p) begin
            if (last_digit) begin
              code_reg      <= buf_ins;
              state_reg     <= S_OPEN;
              digit_idx_reg <= '0;
              buf_reg       <= '0;
            end else begin
              buf_reg       <= buf_ins;
              digit_idx_reg <= digit_idx_reg + IW'(1);
            end
          end
        end
        default: state_reg <= S_LOCKED;
      endcase
    end
  end

  assign is_open    = (state_reg == S_OPEN) || (state_reg == S_SET_ENTRY);
  assign set_mode   = (state_reg == S_SET_ENTRY);
  assign locked_out = (state_reg == S_LOCKOUT);
  assign digit_idx  = digit_idx_reg;
  assign tries_left = tries_reg;
  assign seg_tens   = seg_encode(int'(tries_reg) / 10);
  assign seg_ones   = seg_encode(int'(tries_reg) % 10);

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with small parameters.
module tb_code_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_chk_n, key_rst_n, key_set_n;
  logic [3:0] pw_sw;
  logic       is_open, locked_out, set_mode;
  logic [1:0] digit_idx;
  logic [1:0] tries_left;
  logic [8:0] seg_tens, seg_ones;

  int checks = 0;
  int errors = 0;
  int lo_cnt = 0;
  int lo_base;

  code_lock_ctrl #(
    .PW_WIDTH(4), .PW_DIGITS(2), .PW_INIT(8'h00),
    .MAX_TRIES(3), .LOCKOUT_CYCLES(20), .DEB_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_chk_n(key_chk_n), .key_rst_n(key_rst_n), .key_set_n(key_set_n),
    .pw_sw(pw_sw),
    .is_open(is_open), .locked_out(locked_out), .set_mode(set_mode),
    .digit_idx(digit_idx), .tries_left(tries_left),
    .seg_tens(seg_tens), .seg_ones(seg_ones)
  );

  always #5 clk = ~clk;

  // Cycles spent with locked_out high.
  always @(posedge clk) lo_cnt <= lo_cnt + (locked_out ? 1 : 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-14s observed %0h expected %0h ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k: 0 = chk, 1 = rst, 2 = set
  task automatic press(input int k, input int lo, input int hi);
    case (k)
      0: key_chk_n = 1'b0;
      1: key_rst_n = 1'b0;
      default: key_set_n = 1'b0;
    endcase
    repeat (lo) @(negedge clk);
    key_chk_n = 1'b1; key_rst_n = 1'b1; key_set_n = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] d);
    pw_sw = d;
    press(0, 12, 12);
  endtask

  task automatic enter(input logic [3:0] d0, input logic [3:0] d1);
    digit(d0);
    digit(d1);
  endtask

  initial begin
    rst_n = 1'b0; key_chk_n = 1'b1; key_rst_n = 1'b1; key_set_n = 1'b1; pw_sw = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_open", is_open, 0);
    check("rst_lockout", locked_out, 0);
    check("rst_setmode", set_mode, 0);
    check("rst_idx", digit_idx, 0);
    check("rst_tries", tries_left, 3);
    check("rst_seg_ones", seg_ones, 9'h04f);
    check("rst_seg_tens", seg_tens, 9'h03f);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    enter(4'h0, 4'h0);
    check("open00", is_open, 1);
    check("open00_tries", tries_left, 3);
    check("open00_ones", seg_ones, 9'h04f);
    check("open00_tens", seg_tens, 9'h03f);

    press(2, 12, 12);
    check("set_mode", set_mode, 1);
    digit(4'h5);
    check("set_idx1", digit_idx, 1);
    digit(4'hA);
    check("set_done", set_mode, 0);
    check("set_done_open", is_open, 1);
    press(1, 12, 12);
    check("relock", is_open, 0);
    enter(4'h5, 4'hA);
    check("open_A5", is_open, 1);
    press(1, 12, 12);
    enter(4'h0, 4'h0);
    check("old_code", is_open, 0);
    check("tries2", tries_left, 2);
    check("tries2_seg", seg_ones, 9'h05b);

    enter(4'h1, 4'h1);
    check("tries1", tries_left, 1);
    digit(4'h1);
    check("lo_idx1", digit_idx, 1);
    lo_base = lo_cnt;
    pw_sw = 4'h1;
    key_chk_n = 1'b0;
    for (int i = 0; i < 40 && !locked_out; i++) @(negedge clk);
    check("lockout_on", locked_out, 1);
    check("tries0", tries_left, 0);
    check("tries0_seg", seg_ones, 9'h03f);
    key_chk_n = 1'b1;
    repeat (6) @(negedge clk);
    key_chk_n = 1'b0;
    repeat (7) @(negedge clk);
    key_chk_n = 1'b1;
    check("lo_still", locked_out, 1);
    check("lo_chk_ign", digit_idx, 0);
    for (int i = 0; i < 40 && locked_out; i++) @(negedge clk);
    check("lo_len", lo_cnt - lo_base, 20);
    check("lo_tries", tries_left, 3);
    check("lo_off_open", is_open, 0);
    repeat (12) @(negedge clk);

    // Restore the reset code.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    digit(4'h5);
    check("part_idx", digit_idx, 1);
    press(1, 12, 12);
    check("clr_idx", digit_idx, 0);
    check("clr_tries", tries_left, 3);
    enter(4'h0, 4'h0);
    check("clr_open", is_open, 1);

    press(2, 12, 12);
    check("set2_mode", set_mode, 1);
    digit(4'h7);
    check("set2_idx", digit_idx, 1);
    press(1, 12, 12);
    check("abort_mode", set_mode, 0);
    check("abort_open", is_open, 1);
    check("abort_idx", digit_idx, 0);
    press(1, 12, 12);
    enter(4'h0, 4'h0);
    check("code_kept", is_open, 1);
    press(1, 12, 12);
    check("relock2", is_open, 0);

    pw_sw = 4'h3;
    key_chk_n = 1'b0; key_rst_n = 1'b0;
    repeat (12) @(negedge clk);
    key_chk_n = 1'b1; key_rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_beats_chk", digit_idx, 0);

    pw_sw = 4'h0;
    press(0, 100, 12);
    check("held_one", digit_idx, 1);
    digit(4'h0);
    check("held_open", is_open, 1);
    press(1, 12, 12);

    enter(4'h1, 4'h1);
    enter(4'h1, 4'h1);
    check("t_1", tries_left, 1);
    digit(4'h1);
    pw_sw = 4'h1;
    key_chk_n = 1'b0;
    for (int i = 0; i < 40 && !locked_out; i++) @(negedge clk);
    key_chk_n = 1'b1;
    check("lo2_on", locked_out, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_lo", locked_out, 0);
    check("async_tries", tries_left, 3);
    check("async_ones", seg_ones, 9'h04f);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
